obi_mem_arbiter: RTL
====================

# obi_mem_arbiter

Parametrised N-port arbiter that merges 32-bit OBI-style requesters (core instruction fetch, core data, vector unit data, …) onto one shared memory port of width MEM_W. It replaces the fixed two-way imem/dmem and sdata/vdata muxing in the SoC wrapper. Port selection is configurable as round-robin or fixed priority. An in-order outstanding-transaction FIFO routes each response back to its requester and steers it to the correct 32-bit lane.

## Interface
- NUM_PORTS, default 3: number of requester ports; range 2..8.
- MEM_W, default 32: memory data width; one of 32, 64, 128.
- MAX_OUTSTANDING, default 4: depth of the outstanding-transaction FIFO; power of two, 2..32.
- RR_MODE, default 1: 1 selects round-robin; 0 selects fixed priority, where port 0 is highest.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NUM_PORTS  per-port request.
- gnt_o  out  NUM_PORTS  per-port grant.
- addr_i  in  NUM_PORTS×32  per-port byte address.
- we_i  in  NUM_PORTS  per-port write enable.
- be_i  in  NUM_PORTS×4  per-port byte enables.
- wdata_i  in  NUM_PORTS×32  per-port write data.
- rvalid_o  out  NUM_PORTS  per-port response valid.
- err_o  out  NUM_PORTS  per-port response error.
- rdata_o  out  NUM_PORTS×32  per-port read data.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_addr_o  out  32  memory address.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  MEM_W/8  memory byte enables.
- mem_wdata_o  out  MEM_W  memory write data.
- mem_rvalid_i  in  1  memory response valid.
- mem_err_i  in  1  memory response error.
- mem_rdata_i  in  MEM_W  memory read data.
- resp_orphan_o  out  1  sticky flag: a response arrived with no transaction outstanding.

## Operation
- **Request rule.** Requesters follow OBI: once req_i[i] is raised, it and the port's address-phase signals stay stable until gnt_o[i].
- **Lane and FIFO entry.** LANE_W = $clog2(MEM_W/32); the lane is addr[LANE_W+1:2], or 0 when MEM_W = 32. Each FIFO entry holds {port index, lane}.
- **Winner selection.** Winner is chosen among ports with req_i high.
  - RR_MODE=1: first requesting port at or after rr_ptr, cyclic.
  - RR_MODE=0: lowest-index requesting port.
- **Lock register.** When mem_req_o is high and mem_gnt_i is low, the winner index is registered in lock_q with lock_v=1. While lock_v=1 the locked port stays the winner, even if a higher-priority request appears. lock_v clears on the handshake.
- **Memory request.** mem_req_o = (any req_i) & ~fifo_full.
  - mem_addr_o and mem_we_o come straight from the winner.
  - mem_be_o = winner be << (4×lane); all other bits are 0.
  - mem_wdata_o = winner wdata replicated into every lane.
- **Grant.** gnt_o[w] = mem_req_o & mem_gnt_i for winner w; all other grant bits are 0.
- **Handshake actions** (mem_req_o & mem_gnt_i):
  - push {w, lane} into the FIFO;
  - RR_MODE=1: rr_ptr ← (w+1) mod NUM_PORTS.
- **Response.** On mem_rvalid_i with the FIFO non-empty, the head entry p is popped.
  - rvalid_o[p]=1 and err_o[p]=mem_err_i.
  - rdata_o[p] = mem_rdata_i[32×lane +: 32].
  - rdata_o of the other ports is 0.
  - Every granted request, read or write, receives exactly one response, in order.
- **Orphan response.** mem_rvalid_i with the FIFO empty is dropped, no rvalid_o is raised, and resp_orphan_o is set; it clears only on reset.
- **FIFO full.** When count == MAX_OUTSTANDING, mem_req_o=0, even if mem_rvalid_i is high that cycle. This avoids a combinational path from rvalid to grant.
- **Simultaneous push and pop.** Allowed when the FIFO is not full; count is unchanged.
- **Pointers.** Read/write pointers are $clog2(MAX_OUTSTANDING) bits and wrap naturally. The count is one bit wider.

## Timing
- **Reset values.** While rst_ni=0: count=0, pointers=0, rr_ptr=0, lock_v=0, resp_orphan_o=0. All outputs are 0; mem_req_o is gated by rst_ni.
- **Request path.** req_i to mem_req_o/gnt_o is combinational, so a grant can occur in the same cycle as the request.
- **Response path.** mem_rvalid_i to rvalid_o is combinational, using the registered FIFO head. Minimum request-to-response latency is therefore one cycle.
- **Register updates.** FIFO, rr_ptr and lock update at the edge following the handshake or response.
- **Reset mid-transaction.** Asserting reset during outstanding transactions discards all entries. Responses arriving after reset release set resp_orphan_o.

## Test plan
- **Single port.** NUM_PORTS=3, MEM_W=32. Port 1 reads 0x100; memory grants immediately and returns rvalid two cycles later with data 0xDEADBEEF → rvalid_o[1]=1, rdata_o[1]=0xDEADBEEF, with no activity on ports 0 and 2.
- **Round-robin fairness.** RR_MODE=1. All three ports request continuously with mem_gnt_i=1 and responses returned each cycle → grant order is 0,1,2,0,1,2.
- **Fixed priority and lock.** RR_MODE=0. Port 2 requests while mem_gnt_i=0; port 0 requests one cycle later; mem_gnt_i then rises → port 2 is granted first (lock), then port 0.
- **Wide lane steering.** MEM_W=64.
  - Port 0 writes 0xA5A5A5A5 to 0x204 with be=0xF → mem_be_o=0xF0, mem_wdata_o=0xA5A5A5A5_A5A5A5A5.
  - Port 0 reads 0x204 with mem_rdata_i=0x11112222_33334444 → rdata_o[0]=0x11112222.
- **Full FIFO.** MAX_OUTSTANDING=4. Four grants with no responses → mem_req_o=0 on the fifth request. One rvalid → mem_req_o=1 the next cycle; responses return to the ports in grant order.
- **Orphan and reset.** Pulse mem_rvalid_i with the FIFO empty → all rvalid_o stay 0 and resp_orphan_o=1; asserting rst_ni=0 then clears it.

Source files
------------

// File: rtl/obi_mem_arbiter.sv
// N-port OBI requester arbiter onto one shared memory port of width MEM_W.
// Round-robin or fixed-priority selection. An in-order FIFO of {port, lane}
// routes each response back to its requester and picks its 32-bit lane.
module obi_mem_arbiter #(
    parameter int NUM_PORTS       = 3,
    parameter int MEM_W           = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RR_MODE         = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_PORTS-1:0]     req_i,
    output logic [NUM_PORTS-1:0]     gnt_o,
    input  logic [NUM_PORTS*32-1:0]  addr_i,
    input  logic [NUM_PORTS-1:0]     we_i,
    input  logic [NUM_PORTS*4-1:0]   be_i,
    input  logic [NUM_PORTS*32-1:0]  wdata_i,
    output logic [NUM_PORTS-1:0]     rvalid_o,
    output logic [NUM_PORTS-1:0]     err_o,
    output logic [NUM_PORTS*32-1:0]  rdata_o,
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    output logic [31:0]              mem_addr_o,
    output logic                     mem_we_o,
    output logic [MEM_W/8-1:0]       mem_be_o,
    output logic [MEM_W-1:0]         mem_wdata_o,
    input  logic                     mem_rvalid_i,
    input  logic                     mem_err_i,
    input  logic [MEM_W-1:0]         mem_rdata_i,
    output logic                     resp_orphan_o
);
    localparam int PW    = $clog2(NUM_PORTS);
    localparam int NLANE = MEM_W / 32;
    // Lane field is kept one bit wide for MEM_W=32 and simply held at 0.
    localparam int LW    = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam int AW    = $clog2(MAX_OUTSTANDING);

    logic [PW-1:0]   r_rr_ptr;
    logic [PW-1:0]   r_lock_q;
    logic            r_lock_v;
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_count;
    logic            r_orphan;
    logic [PW-1:0]   r_fifo_port [MAX_OUTSTANDING];
    logic [LW-1:0]   r_fifo_lane [MAX_OUTSTANDING];

    logic [PW-1:0]   w_win;
    logic [LW-1:0]   w_lane;
    logic [31:0]     w_addr;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic            w_full, w_empty, w_push, w_pop;
    logic [PW-1:0]   w_head_p;
    logic [LW-1:0]   w_head_l;

    // First requesting port at or after 'start', cyclic.
    function automatic logic [PW-1:0] f_pick(input logic [NUM_PORTS-1:0] req,
                                             input logic [PW-1:0] start);
        logic [PW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(start) + k) % NUM_PORTS;
            if (!found && req[idx]) begin
                sel   = PW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_full   = (r_count == (AW+1)'(MAX_OUTSTANDING));
    assign w_empty  = (r_count == '0);
    assign w_head_p = r_fifo_port[r_rptr];
    assign w_head_l = r_fifo_lane[r_rptr];
    assign w_push   = mem_req_o & mem_gnt_i;
    assign w_pop    = mem_rvalid_i & ~w_empty;
    assign resp_orphan_o = r_orphan;

    // Winner selection and request-side muxing; a stalled winner stays locked.
    always_comb begin
        w_win = r_lock_v ? r_lock_q : f_pick(req_i, (RR_MODE != 0) ? r_rr_ptr : '0);
        w_addr  = addr_i[32*w_win +: 32];
        w_be    = be_i[4*w_win +: 4];
        w_wdata = wdata_i[32*w_win +: 32];
        if (NLANE > 1) w_lane = w_addr[LW+1:2];
        else           w_lane = '0;

        mem_req_o   = rst_ni & (|req_i) & ~w_full;
        mem_addr_o  = rst_ni ? w_addr : '0;
        mem_we_o    = rst_ni & we_i[w_win];
        mem_be_o    = '0;
        if (rst_ni) mem_be_o[4*w_lane +: 4] = w_be;
        mem_wdata_o = rst_ni ? {NLANE{w_wdata}} : '0;
        gnt_o       = '0;
        gnt_o[w_win] = mem_req_o & mem_gnt_i;
    end

    // Response steering from the registered FIFO head.
    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        if (w_pop) begin
            rvalid_o[w_head_p]           = 1'b1;
            err_o[w_head_p]              = mem_err_i;
            rdata_o[32*w_head_p +: 32]   = mem_rdata_i[32*w_head_l +: 32];
        end
    end

    // Pointers, count, round-robin pointer, lock and orphan flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
            r_lock_q <= '0;
            r_lock_v <= 1'b0;
            r_orphan <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (w_push && RR_MODE != 0)
                r_rr_ptr <= PW'((int'(w_win) + 1) % NUM_PORTS);
            if (mem_req_o && !mem_gnt_i) begin
                r_lock_q <= w_win;
                r_lock_v <= 1'b1;
            end else if (w_push) begin
                r_lock_v <= 1'b0;
            end
            if (mem_rvalid_i && w_empty) r_orphan <= 1'b1;
        end
    end

    // FIFO storage; contents are only meaningful below the count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_port[r_wptr] <= w_win;
            r_fifo_lane[r_wptr] <= w_lane;
        end
    end
endmodule
